// File: rtl/sc_regbank_scan.sv
// DEPTH x WIDTH register bank with one write port, two combinational
// read ports, optional write-through bypass and a full-length scan chain.
module sc_regbank_scan #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b0,
  localparam int unsigned     AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RADDR0,
  output logic [WIDTH-1:0] Q0,
  input  logic [AW-1:0]    RADDR1,
  output logic [WIDTH-1:0] Q1,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
);

  localparam int unsigned N = WIDTH * DEPTH;

  // Word n occupies bits [n*WIDTH +: WIDTH]; this is also the scan order.
  logic [N-1:0]     mem_q;
  logic [N-1:0]     mem_d;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic             wr_live;
  logic             unused_supply;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign unused_supply = ^{VPW, VNW, VDD, VSS};

  always_comb begin
    mem_d = mem_q;
    if (SE) begin
      mem_d[0] = SI;
      for (int i = 1; i < int'(N); i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end else if (WE && in_range(WADDR)) begin
      mem_d[32'(WADDR)*WIDTH +: WIDTH] = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= {DEPTH{RESET_VAL}};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (in_range(RADDR0)) rd0 = mem_q[32'(RADDR0)*WIDTH +: WIDTH];
    if (in_range(RADDR1)) rd1 = mem_q[32'(RADDR1)*WIDTH +: WIDTH];
  end

  assign wr_live = WE & ~SE & ~RST & in_range(WADDR);

  assign Q0 = (BYPASS && wr_live && (WADDR == RADDR0)) ? D : rd0;
  assign Q1 = (BYPASS && wr_live && (WADDR == RADDR1)) ? D : rd1;
  assign SO = mem_q[N-1];

endmodule

// File: tb/tb_sc_regbank_scan.sv
// Directed bench: 8x4 banks with and without bypass, plus an 8x3 bank
// for the non-power-of-two depth and 24-bit scan chain.
module tb_sc_regbank_scan;

  logic       clk = 1'b0;
  logic       rst, we, se, si, se2, si2;
  logic [1:0] waddr, raddr0, raddr1;
  logic [7:0] d;
  logic [7:0] q0_a, q1_a, q0_b, q1_b, q0_c, q1_c;
  logic       so_a, so_b, so_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sc_regbank_scan #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .BYPASS(1'b0)) u_a (
    .CLK(clk), .RST(rst), .VPW(1'b1), .VNW(1'b0), .VDD(1'b1), .VSS(1'b0),
    .WE(we), .WADDR(waddr), .D(d), .RADDR0(raddr0), .Q0(q0_a),
    .RADDR1(raddr1), .Q1(q1_a), .SE(se), .SI(si), .SO(so_a));

  sc_regbank_scan #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .BYPASS(1'b1)) u_b (
    .CLK(clk), .RST(rst), .VPW(1'b1), .VNW(1'b0), .VDD(1'b1), .VSS(1'b0),
    .WE(we), .WADDR(waddr), .D(d), .RADDR0(raddr0), .Q0(q0_b),
    .RADDR1(raddr1), .Q1(q1_b), .SE(se), .SI(si), .SO(so_b));

  sc_regbank_scan #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .BYPASS(1'b0)) u_c (
    .CLK(clk), .RST(rst), .VPW(1'b1), .VNW(1'b0), .VDD(1'b1), .VSS(1'b0),
    .WE(we), .WADDR(waddr), .D(d), .RADDR0(raddr0), .Q0(q0_c),
    .RADDR1(raddr1), .Q1(q1_c), .SE(se2), .SI(si2), .SO(so_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; se = 1'b0; se2 = 1'b0;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      raddr0 = 2'(r); raddr1 = 2'(3 - r);
      #1;
      checks++;
      if (q0_a !== 8'hA5 || q1_a !== 8'hA5) begin
        $display("FAIL reset_a r=%0d q0=%h q1=%h want a5", r, q0_a, q1_a);
        errors++;
      end
      checks++;
      if (q0_b !== 8'hA5 || q1_b !== 8'hA5) begin
        $display("FAIL reset_b r=%0d q0=%h q1=%h want a5", r, q0_b, q1_b);
        errors++;
      end
      if (r < 3) begin
        checks++;
        if (q0_c !== 8'hA5) begin
          $display("FAIL reset_c r=%0d q0=%h want a5", r, q0_c);
          errors++;
        end
      end
    end
    checks++;
    if (so_a !== 1'b1 || so_b !== 1'b1 || so_c !== 1'b1) begin
      $display("FAIL reset_so got %b%b%b want 111", so_a, so_b, so_c);
      errors++;
    end
  endtask

  task automatic test_write_dual_read;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int a = 0; a < 4; a++) begin
      we = 1'b1; waddr = 2'(a); d = vals[a];
      tick();
    end
    we = 1'b0;
    raddr0 = 2'd2; raddr1 = 2'd3;
    #1;
    checks++;
    if (q0_a !== 8'h33 || q1_a !== 8'h44) begin
      $display("FAIL dual_read_a q0=%h q1=%h want 33 44", q0_a, q1_a);
      errors++;
    end
    checks++;
    if (q0_b !== 8'h33 || q1_b !== 8'h44) begin
      $display("FAIL dual_read_b q0=%h q1=%h want 33 44", q0_b, q1_b);
      errors++;
    end
    checks++;
    if (q0_c !== 8'h33 || q1_c !== 8'h00) begin
      $display("FAIL dual_read_c q0=%h q1=%h want 33 00", q0_c, q1_c);
      errors++;
    end
  endtask

  task automatic test_same_cycle;
    we = 1'b1; waddr = 2'd1; d = 8'hC3; raddr0 = 2'd1; raddr1 = 2'd0;
    #1;
    checks++;
    if (q0_a !== 8'h22) begin
      $display("FAIL same_cycle_nobyp got %h want 22", q0_a);
      errors++;
    end
    checks++;
    if (q0_b !== 8'hC3 || q1_b !== 8'h11) begin
      $display("FAIL same_cycle_byp q0=%h q1=%h want c3 11", q0_b, q1_b);
      errors++;
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (q0_a !== 8'hC3 || q0_b !== 8'hC3) begin
      $display("FAIL after_write a=%h b=%h want c3", q0_a, q0_b);
      errors++;
    end
  endtask

  task automatic test_scan;
    logic [31:0] orig;
    logic [31:0] v;
    logic [7:0]  got [4];
    orig = 32'h4433C311;
    v    = 32'hDEADBEEF;
    se = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      si = orig[32-k];
      #1;
      checks++;
      if (so_a !== orig[32-k]) begin
        $display("FAIL scan_so k=%0d got %b want %b", k, so_a, orig[32-k]);
        errors++;
      end
      tick();
    end
    se = 1'b0;
    for (int n = 0; n < 4; n++) begin
      raddr0 = 2'(n);
      #1;
      got[n] = q0_a;
      checks++;
      if (q0_a !== orig[n*8 +: 8] || q0_b !== orig[n*8 +: 8]) begin
        $display("FAIL scan_roundtrip w%0d a=%h b=%h want %h",
                 n, q0_a, q0_b, orig[n*8 +: 8]);
        errors++;
      end
    end
    se = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      si = v[32-k];
      tick();
    end
    se = 1'b0;
    for (int n = 0; n < 4; n++) begin
      raddr0 = 2'(n); raddr1 = 2'(n);
      #1;
      checks++;
      if (q0_a !== v[n*8 +: 8] || q1_a !== v[n*8 +: 8]) begin
        $display("FAIL scan_in w%0d q0=%h q1=%h want %h",
                 n, q0_a, q1_a, v[n*8 +: 8]);
        errors++;
      end
    end
  endtask

  task automatic test_priority;
    logic [7:0] exp_w [4];
    exp_w = '{8'h4A, 8'h4B, 8'h4B, 8'h4B};
    rst = 1'b1; se = 1'b1; we = 1'b1; waddr = 2'd0; d = 8'h00; si = 1'b0;
    tick();
    rst = 1'b0;
    raddr0 = 2'd0;
    #1;
    checks++;
    if (q0_a !== 8'hA5 || q0_b !== 8'hA5) begin
      $display("FAIL prio_rst a=%h b=%h want a5 (bypass must ignore SE)",
               q0_a, q0_b);
      errors++;
    end
    tick();
    se = 1'b0; we = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) begin
      raddr0 = 2'(n);
      #1;
      checks++;
      if (q0_a !== exp_w[n]) begin
        $display("FAIL prio_shift w%0d got %h want %h", n, q0_a, exp_w[n]);
        errors++;
      end
    end
    checks++;
    if (so_a !== 1'b0) begin
      $display("FAIL prio_so got %b want 0", so_a);
      errors++;
    end
  endtask

  task automatic test_nonpow2;
    logic [7:0]  vals [3];
    logic [23:0] orig;
    logic [23:0] v;
    vals = '{8'h12, 8'h34, 8'h56};
    orig = 24'h563412;
    v    = 24'h9ABCDE;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 3; a++) begin
      we = 1'b1; waddr = 2'(a); d = vals[a];
      tick();
    end
    waddr = 2'd3; d = 8'hFF;
    tick();
    we = 1'b0;
    for (int n = 0; n < 3; n++) begin
      raddr0 = 2'(n);
      #1;
      checks++;
      if (q0_c !== vals[n]) begin
        $display("FAIL oor_write w%0d got %h want %h", n, q0_c, vals[n]);
        errors++;
      end
    end
    raddr0 = 2'd3; raddr1 = 2'd3;
    #1;
    checks++;
    if (q0_c !== 8'h00 || q1_c !== 8'h00) begin
      $display("FAIL oor_read q0=%h q1=%h want 00", q0_c, q1_c);
      errors++;
    end
    se2 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      si2 = v[24-k];
      #1;
      checks++;
      if (so_c !== orig[24-k]) begin
        $display("FAIL scan24_so k=%0d got %b want %b", k, so_c, orig[24-k]);
        errors++;
      end
      tick();
    end
    se2 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      raddr0 = 2'(n);
      #1;
      checks++;
      if (q0_c !== v[n*8 +: 8]) begin
        $display("FAIL scan24_in w%0d got %h want %h", n, q0_c, v[n*8 +: 8]);
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; se = 1'b0; si = 1'b0; se2 = 1'b0; si2 = 1'b0;
    waddr = '0; raddr0 = '0; raddr1 = '0; d = '0;
    test_reset();
    test_write_dual_read();
    test_same_cycle();
    test_scan();
    test_priority();
    test_nonpow2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_regbank_scan.md
# sc_regbank_scan

Parametrised multi-word register bank built on the same edge-triggered storage semantics as the library's D flip-flop cell. It generalises the single-bit flop to DEPTH words of WIDTH bits. It adds synchronous reset, one write port, two combinational read ports with optional write-through bypass, and a full-length scan chain for DFT. It sits in the standard-cell library as a characterised macro for small register files and configuration banks in MCU designs.

## Interface
Parameters:
- WIDTH, 8, bits per word (>= 1)
- DEPTH, 4, number of words (>= 1, need not be a power of two)
- RESET_VAL, 0, value every word takes on reset (WIDTH bits)
- BYPASS, 0, 1 = read port returns D when WE targets the read address in the same cycle

Ports (AW = max(1, clog2(DEPTH))):
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- VPW, VNW, VDD, VSS  input  1 each  bias/supply pins, no functional effect
- WE  input  1  write enable
- WADDR  input  AW  write address
- D  input  WIDTH  write data
- RADDR0  input  AW  read address, port 0
- Q0  output  WIDTH  read data, port 0
- RADDR1  input  AW  read address, port 1
- Q1  output  WIDTH  read data, port 1
- SE  input  1  scan enable
- SI  input  1  scan in
- SO  output  1  scan out

## Operation
- Storage: DEPTH x WIDTH flops, word n = mem[n].
- Per-edge priority: RST, then SE, then WE, then hold.
- RST=1: every word loads RESET_VAL. SE and WE are ignored.
- SE=1 (RST=0): the whole array shifts by one bit along the chain SI -> mem[0][0] -> mem[0][1] -> ... -> mem[0][WIDTH-1] -> mem[1][0] -> ... -> mem[DEPTH-1][WIDTH-1]. WE is ignored. Chain length is WIDTH*DEPTH.
- SO = mem[DEPTH-1][WIDTH-1] at all times. It is a flop output, not combinational from SI.
- WE=1 (RST=0, SE=0): mem[WADDR] <= D if WADDR < DEPTH. An out-of-range WADDR is a no-op; no word changes.
- Reads are combinational: Qk = mem[RADDRk] if RADDRk < DEPTH, else all zeros.
- BYPASS=0: a same-cycle write to the read address is not visible until after the edge.
- BYPASS=1: if WE=1, SE=0, RST=0, WADDR == RADDRk and WADDR < DEPTH, then Qk = D combinationally. Otherwise stored data is returned.
- Both read ports are independent. They may address the same word or the write word simultaneously.
- Supply pins are unused in RTL but must be present on the port list.

## Timing
- Reset: from the first CLK edge with RST=1, Q0/Q1 reflect RESET_VAL for any in-range address. SO = RESET_VAL[WIDTH-1].
- Before the first reset, state is X. The bench must not check outputs before reset.
- Write latency: 1 edge. Data is visible on Q in the cycle after the write edge (0 cycles with BYPASS=1).
- Scan: after N edges with SE=1, the bit presented on SI at edge 1 reaches chain position N-1. The original mem[DEPTH-1][WIDTH-1] exits on SO before edge 1. The bit at chain position P appears on SO after (WIDTH*DEPTH-1-P) edges.
- Reset mid-scan or mid-write: the reset edge wins and partial shifts are discarded. The next edge with RST=0 resumes normal priority.
- SE deasserted mid-chain: the array holds its partially shifted contents. No restore.
- Reads have no clock dependency except through storage updates.

## Test plan
- Reset/readback (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5): RST one edge -> Q0=Q1=8'hA5 for all RADDR 0..3; SO=1.
- Write/dual read: write 8'h11,8'h22,8'h33,8'h44 to addresses 0..3, then RADDR0=2, RADDR1=3 -> Q0=8'h33, Q1=8'h44.
- Same-cycle write/read: WE=1, WADDR=1, D=8'hC3, RADDR0=1, holding 8'h22 -> before the edge Q0=8'h22 (BYPASS=0) or 8'hC3 (BYPASS=1); after the edge Q0=8'hC3 in both cases.
- Scan round-trip: load a known pattern and SE=1 for 32 edges with SI feeding back from SO -> the array equals the original pattern. Also shift in 32 bits from SI -> Q0..Q3 match the bit order defined above.
- Priority: RST=1, SE=1, WE=1 on one edge -> all words become RESET_VAL. Then SE=1, WE=1 -> only the shift occurs and mem[WADDR] does not take D.
- Non-power-of-two (DEPTH=3, AW=2): write to WADDR=3 -> no word changes. RADDR0=3 -> Q0=0. Scan chain length is 24 edges.
